// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit:
// opcode/func constants, ALU operation codes, FSM state codes and the
// instruction-class enum produced by mc_decode.
package mc_pkg;

  // Opcodes, instruction[31:26]
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  // R-type func codes, instruction[5:0]
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_HAM = 6'b111111;

  // ALU operation codes (consumer is the ALU's aluc input)
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;
  localparam logic [3:0] ALU_HAM = 4'b1011;

  // FSM state encoding
  localparam logic [2:0] ST_IF  = 3'd0;
  localparam logic [2:0] ST_ID  = 3'd1;
  localparam logic [2:0] ST_EXE = 3'd2;
  localparam logic [2:0] ST_MEM = 3'd3;
  localparam logic [2:0] ST_WB  = 3'd4;

  typedef enum logic [2:0] {
    CL_RALU    = 3'd0,
    CL_IALU    = 3'd1,
    CL_LOAD    = 3'd2,
    CL_STORE   = 3'd3,
    CL_BRANCH  = 3'd4,
    CL_JUMP    = 3'd5,
    CL_ILLEGAL = 3'd6
  } instr_class_e;

  // Shift-type R instructions take the shift amount as ALU operand A
  function automatic logic is_shift_fn(input logic [5:0] fn);
    return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: classifies op/func and produces the
// ALU code and the operand/destination qualifiers used by the FSM.
// HAM_EN: when defined, R-type func 111111 decodes as HAM; otherwise illegal.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0]   op,
  input  logic [5:0]   func,
  output instr_class_e cls,
  output logic [3:0]   aluc,
  output logic         shift,
  output logic         sext,
  output logic         regrt
);

  // Decode op/func into class, ALU code and operand qualifiers
  always_comb begin
    cls   = CL_ILLEGAL;
    aluc  = ALU_ADD;
    shift = 1'b0;
    sext  = 1'b0;
    regrt = 1'b0;
    case (op)
      OP_R: begin
        cls   = CL_RALU;
        shift = is_shift_fn(func);
        case (func)
          FN_ADD:  aluc = ALU_ADD;
          FN_SUB:  aluc = ALU_SUB;
          FN_AND:  aluc = ALU_AND;
          FN_OR:   aluc = ALU_OR;
          FN_XOR:  aluc = ALU_XOR;
          FN_SLL:  aluc = ALU_SLL;
          FN_SRL:  aluc = ALU_SRL;
          FN_SRA:  aluc = ALU_SRA;
          FN_JR:   cls  = CL_JUMP;
`ifdef HAM_EN
          FN_HAM:  aluc = ALU_HAM;
`endif
          default: cls  = CL_ILLEGAL;
        endcase
      end
      OP_J, OP_JAL:   cls = CL_JUMP;
      OP_BEQ, OP_BNE: begin
        cls  = CL_BRANCH;
        aluc = ALU_SUB;
      end
      OP_ADDI: begin cls = CL_IALU; aluc = ALU_ADD; sext = 1'b1; regrt = 1'b1; end
      OP_ANDI: begin cls = CL_IALU; aluc = ALU_AND; regrt = 1'b1; end
      OP_ORI:  begin cls = CL_IALU; aluc = ALU_OR;  regrt = 1'b1; end
      OP_XORI: begin cls = CL_IALU; aluc = ALU_XOR; regrt = 1'b1; end
      OP_LUI:  begin cls = CL_IALU; aluc = ALU_LUI; regrt = 1'b1; end
      OP_LW:   begin cls = CL_LOAD;  sext = 1'b1; regrt = 1'b1; end
      OP_SW:   begin cls = CL_STORE; sext = 1'b1; end
      default: cls = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM (IF/ID/EXE/MEM/WB) for the MIPS-subset CPU.
// All datapath controls are combinational from state, op, func, z, mem_ready.
// HAM_EN: enables the HAM R-type instruction (func 111111) in mc_decode.
// NONE_ILLEGAL_WAIT: IF cycles inserted after an illegal op before refetch.
module mc_control
  import mc_pkg::*;
#(
  parameter int unsigned NONE_ILLEGAL_WAIT = 0
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_ready,
  output logic       wpc,
  output logic       wir,
  output logic       wmem,
  output logic       wreg,
  output logic       iord,
  output logic       regrt,
  output logic       m2reg,
  output logic       jal,
  output logic       sext,
  output logic       shift,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic [3:0] aluc,
  output logic [2:0] state,
  output logic       illegal
);

  localparam int unsigned WW = (NONE_ILLEGAL_WAIT > 0) ? $clog2(NONE_ILLEGAL_WAIT + 1) : 1;
  localparam logic [WW-1:0] WAIT_LOAD = WW'(NONE_ILLEGAL_WAIT);

  logic [2:0]    state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;

  instr_class_e dec_cls;
  logic [3:0]   dec_aluc;
  logic         dec_shift, dec_sext, dec_regrt;

  mc_decode u_decode (
    .op    (op),
    .func  (func),
    .cls   (dec_cls),
    .aluc  (dec_aluc),
    .shift (dec_shift),
    .sext  (dec_sext),
    .regrt (dec_regrt)
  );

  assign state = state_q;

  // Next-state and datapath control generation; reset forces IF with all controls low
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    wpc      = 1'b0;
    wir      = 1'b0;
    wmem     = 1'b0;
    wreg     = 1'b0;
    iord     = 1'b0;
    regrt    = 1'b0;
    m2reg    = 1'b0;
    jal      = 1'b0;
    sext     = 1'b0;
    shift    = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsource = 2'b00;
    aluc     = ALU_ADD;
    illegal  = 1'b0;
    if (!resetn) begin
      state_d = ST_IF;
      wait_d  = '0;
    end else begin
      case (state_q)
        ST_IF: begin
          alusrcb = 2'b01;
          if (wait_q != '0) begin
            wait_d = wait_q - WW'(1);
          end else if (mem_ready) begin
            wir     = 1'b1;
            wpc     = 1'b1;
            state_d = ST_ID;
          end else begin
            state_d = ST_IF;
          end
        end
        ST_ID: begin
          // Precompute the branch target into ALUout
          alusrcb = 2'b11;
          sext    = 1'b1;
          if (dec_cls == CL_JUMP) begin
            wpc     = 1'b1;
            state_d = ST_IF;
            if (op == OP_R) begin
              pcsource = 2'b11;
            end else begin
              pcsource = 2'b10;
              wreg     = (op == OP_JAL);
              jal      = (op == OP_JAL);
            end
          end else if (dec_cls == CL_ILLEGAL) begin
            illegal = 1'b1;
            wait_d  = WAIT_LOAD;
            state_d = ST_IF;
          end else begin
            state_d = ST_EXE;
          end
        end
        ST_EXE: begin
          alusrca = 1'b1;
          aluc    = dec_aluc;
          case (dec_cls)
            CL_RALU: begin
              shift   = dec_shift;
              state_d = ST_WB;
            end
            CL_IALU: begin
              alusrcb = 2'b10;
              sext    = dec_sext;
              state_d = ST_WB;
            end
            CL_LOAD, CL_STORE: begin
              alusrcb = 2'b10;
              sext    = 1'b1;
              state_d = ST_MEM;
            end
            CL_BRANCH: begin
              pcsource = 2'b01;
              wpc      = (op == OP_BEQ) ? z : ~z;
              state_d  = ST_IF;
            end
            default: state_d = ST_IF;
          endcase
        end
        ST_MEM: begin
          iord = 1'b1;
          if (dec_cls == CL_STORE) begin
            wmem    = mem_ready;
            state_d = mem_ready ? ST_IF : ST_MEM;
          end else if (dec_cls == CL_LOAD) begin
            state_d = mem_ready ? ST_WB : ST_MEM;
          end else begin
            state_d = ST_IF;
          end
        end
        ST_WB: begin
          wreg    = 1'b1;
          regrt   = dec_regrt;
          m2reg   = (dec_cls == CL_LOAD);
          state_d = ST_IF;
        end
        default: state_d = ST_IF;
      endcase
    end
  end

  // State and illegal-wait registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_IF;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed self-checking bench for mc_control. Inputs change on the falling
// edge; outputs are sampled 1 time unit later, away from the rising edge.
module tb_mc_control;

  logic       clock, resetn, z, mem_ready;
  logic [5:0] op, func;
  logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift, alusrca, illegal;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] aluc;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  mc_control dut (
    .clock(clock), .resetn(resetn), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
    .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg), .iord(iord), .regrt(regrt),
    .m2reg(m2reg), .jal(jal), .sext(sext), .shift(shift), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsource(pcsource), .aluc(aluc), .state(state), .illegal(illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic test_reset();
    resetn = 1'b0; mem_ready = 1'b1; z = 1'b0; op = 6'b101011; func = 6'b000000;
    tick(); tick(); #1;
    total++;
    if (state !== 3'd0) begin bad++; $display("FAIL reset_state got %0d want 0", state); end
    total++;
    if ({wpc, wir, wmem, wreg, illegal} !== 5'b00000) begin
      bad++; $display("FAIL reset_enables got %b want 00000", {wpc, wir, wmem, wreg, illegal});
    end
    total++;
    if ({aluc, alusrcb, pcsource, iord, alusrca, regrt, m2reg, jal, sext, shift} !== 15'd0) begin
      bad++; $display("FAIL reset_selects got %b want 0", {aluc, alusrcb, pcsource, iord, alusrca, regrt, m2reg, jal, sext, shift});
    end
    // Release reset with memory not ready: IF must hold without writing IR/PC
    tick(); resetn = 1'b1; mem_ready = 1'b0; #1;
    total++;
    if ({state, wir, wpc, iord, alusrcb} !== {3'd0, 1'b0, 1'b0, 1'b0, 2'b01}) begin
      bad++; $display("FAIL if_wait got %b want 00000001", {state, wir, wpc, iord, alusrcb});
    end
    tick(); #1;
    total++;
    if (state !== 3'd0) begin bad++; $display("FAIL if_hold got %0d want 0", state); end
  endtask

  task automatic test_add();
    op = 6'b000000; func = 6'b100000; mem_ready = 1'b1; #1;
    total++;
    if ({state, wir, wpc} !== {3'd0, 2'b11}) begin bad++; $display("FAIL add_if got %b want 00011", {state, wir, wpc}); end
    tick(); #1;
    total++;
    if ({state, alusrcb, sext, wpc} !== {3'd1, 2'b11, 1'b1, 1'b0}) begin
      bad++; $display("FAIL add_id got %b want 0011110", {state, alusrcb, sext, wpc});
    end
    tick(); #1;
    total++;
    if ({state, aluc, alusrca, alusrcb, shift} !== {3'd2, 4'b0000, 1'b1, 2'b00, 1'b0}) begin
      bad++; $display("FAIL add_exe got %b want 0100000100", {state, aluc, alusrca, alusrcb, shift});
    end
    tick(); #1;
    total++;
    if ({state, wreg, regrt, m2reg} !== {3'd4, 3'b100}) begin
      bad++; $display("FAIL add_wb got %b want 100100", {state, wreg, regrt, m2reg});
    end
    tick(); #1;
    total++;
    if (state !== 3'd0) begin bad++; $display("FAIL add_ret got %0d want 0", state); end
  endtask

  task automatic test_sra();
    op = 6'b000000; func = 6'b000011; mem_ready = 1'b1;
    tick(); tick(); #1;
    total++;
    if ({state, aluc, shift} !== {3'd2, 4'b1111, 1'b1}) begin
      bad++; $display("FAIL sra_exe got %b want 01011111", {state, aluc, shift});
    end
    tick(); tick(); #1;
  endtask

  task automatic test_ori();
    op = 6'b001101; func = 6'b000000; mem_ready = 1'b1;
    tick(); tick(); #1;
    total++;
    if ({state, aluc, alusrca, alusrcb, sext} !== {3'd2, 4'b0101, 1'b1, 2'b10, 1'b0}) begin
      bad++; $display("FAIL ori_exe got %b want 0100101110", {state, aluc, alusrca, alusrcb, sext});
    end
    tick(); #1;
    total++;
    if ({state, wreg, regrt, m2reg} !== {3'd4, 3'b110}) begin
      bad++; $display("FAIL ori_wb got %b want 100110", {state, wreg, regrt, m2reg});
    end
    tick(); #1;
  endtask

  task automatic test_lw_wait();
    op = 6'b100011; func = 6'b000000; mem_ready = 1'b1; #1;
    tick(); tick(); #1;
    total++;
    if ({state, aluc, alusrcb, sext} !== {3'd2, 4'b0000, 2'b10, 1'b1}) begin
      bad++; $display("FAIL lw_exe got %b want 0100000101", {state, aluc, alusrcb, sext});
    end
    mem_ready = 1'b0;
    tick(); #1;
    total++;
    if ({state, iord} !== {3'd3, 1'b1}) begin bad++; $display("FAIL lw_mem1 got %b want 0111", {state, iord}); end
    tick(); #1;
    total++;
    if (state !== 3'd3) begin bad++; $display("FAIL lw_mem2 got %0d want 3", state); end
    tick(); #1;
    total++;
    if ({state, wmem} !== {3'd3, 1'b0}) begin bad++; $display("FAIL lw_mem3 got %b want 0110", {state, wmem}); end
    mem_ready = 1'b1;
    tick(); #1;
    total++;
    if ({state, wreg, m2reg, regrt} !== {3'd4, 3'b111}) begin
      bad++; $display("FAIL lw_wb got %b want 100111", {state, wreg, m2reg, regrt});
    end
    tick(); #1;
    total++;
    if (state !== 3'd0) begin bad++; $display("FAIL lw_ret got %0d want 0", state); end
  endtask

  task automatic test_branch(input logic [5:0] bop, input logic zin, input logic exp_wpc);
    op = bop; func = 6'b000000; z = zin; mem_ready = 1'b1;
    tick(); tick(); #1;
    total++;
    if ({state, wpc, pcsource, aluc, alusrca, alusrcb} !== {3'd2, exp_wpc, 2'b01, 4'b0100, 1'b1, 2'b00}) begin
      bad++; $display("FAIL branch_exe op=%b got %b want %b", bop, {state, wpc, pcsource, aluc, alusrca, alusrcb},
                      {3'd2, exp_wpc, 2'b01, 4'b0100, 1'b1, 2'b00});
    end
    tick(); #1;
    total++;
    if (state !== 3'd0) begin bad++; $display("FAIL branch_ret op=%b got %0d want 0", bop, state); end
    z = 1'b0;
  endtask

  task automatic test_jumps();
    op = 6'b000011; func = 6'b000000; mem_ready = 1'b1;
    tick(); #1;
    total++;
    if ({state, wpc, wreg, jal, pcsource} !== {3'd1, 3'b111, 2'b10}) begin
      bad++; $display("FAIL jal_id got %b want 00111110", {state, wpc, wreg, jal, pcsource});
    end
    tick(); #1;
    total++;
    if (state !== 3'd0) begin bad++; $display("FAIL jal_ret got %0d want 0", state); end
    op = 6'b000000; func = 6'b001000;
    tick(); #1;
    total++;
    if ({state, wpc, wreg, jal, pcsource} !== {3'd1, 3'b100, 2'b11}) begin
      bad++; $display("FAIL jr_id got %b want 00110011", {state, wpc, wreg, jal, pcsource});
    end
    tick(); #1;
  endtask

  task automatic test_ham();
    op = 6'b000000; func = 6'b111111; mem_ready = 1'b1;
    tick(); #1;
`ifdef HAM_EN
    tick(); #1;
    total++;
    if ({state, aluc, alusrca} !== {3'd2, 4'b1011, 1'b1}) begin
      bad++; $display("FAIL ham_exe got %b want 01010111", {state, aluc, alusrca});
    end
    tick(); #1;
    total++;
    if ({state, wreg} !== {3'd4, 1'b1}) begin bad++; $display("FAIL ham_wb got %b want 1001", {state, wreg}); end
    tick(); #1;
`else
    total++;
    if ({state, illegal, wreg, wpc} !== {3'd1, 3'b100}) begin
      bad++; $display("FAIL ham_illegal got %b want 001100", {state, illegal, wreg, wpc});
    end
    mem_ready = 1'b0;
    tick(); #1;
    total++;
    if ({state, illegal, wreg} !== {3'd0, 2'b00}) begin
      bad++; $display("FAIL ham_after got %b want 00000", {state, illegal, wreg});
    end
    mem_ready = 1'b1;
`endif
  endtask

  task automatic test_illegal_op();
    op = 6'b111111; func = 6'b100000; mem_ready = 1'b1;
    tick(); #1;
    total++;
    if ({state, illegal} !== {3'd1, 1'b1}) begin bad++; $display("FAIL illop_id got %b want 0011", {state, illegal}); end
    tick(); #1;
    total++;
    if ({state, illegal} !== {3'd0, 1'b0}) begin bad++; $display("FAIL illop_ret got %b want 0000", {state, illegal}); end
  endtask

  task automatic test_sw_reset();
    op = 6'b101011; func = 6'b000000; mem_ready = 1'b1;
    tick(); tick(); tick(); #1;
    total++;
    if ({state, wmem, iord} !== {3'd3, 2'b11}) begin bad++; $display("FAIL sw_mem got %b want 01111", {state, wmem, iord}); end
    tick(); #1;
    total++;
    if (state !== 3'd0) begin bad++; $display("FAIL sw_ret got %0d want 0", state); end
    tick(); tick(); tick(); #1;
    resetn = 1'b0; #1;
    total++;
    if ({state, wmem, wpc, wreg} !== {3'd3, 3'b000}) begin
      bad++; $display("FAIL sw_rst_mem got %b want 011000", {state, wmem, wpc, wreg});
    end
    tick(); #1;
    total++;
    if ({state, wmem} !== {3'd0, 1'b0}) begin bad++; $display("FAIL sw_rst_next got %b want 0000", {state, wmem}); end
    resetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sra();
    test_ori();
    test_lw_wait();
    test_branch(6'b000100, 1'b1, 1'b1);
    test_branch(6'b000101, 1'b1, 1'b0);
    test_branch(6'b000101, 1'b0, 1'b1);
    test_jumps();
    test_ham();
    test_illegal_op();
    test_sw_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
